// File: rtl/data_sram_ctrl.sv
// data_sram_ctrl: MEM-stage data port to asynchronous SRAM bridge.
// Each accepted request becomes a multi-cycle SRAM transaction with
// programmable read/write wait states; the pipeline is held via stallreq_o.
module data_sram_ctrl #(
  parameter int ADDR_W  = 18,
  parameter int RD_WAIT = 2,   // 1..15
  parameter int WR_WAIT = 2    // 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_data_o,
  input  logic [31:0]       sram_data_i,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o
);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, DONE} state_t;

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  state_t     state, state_nxt;
  logic [3:0] wcnt;
  logic       abandon;
  logic       flush;
  logic       busy;

  // Byte-offset bits and address bits above the SRAM window alias away.
  logic unused_addr;
  assign unused_addr = &{1'b0, mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

  // A flushed transaction (ce dropped at any point) retires straight to IDLE.
  assign flush = abandon | ~mem_ce_i;
  assign busy  = (state == RD) || (state == WR_SETUP) || (state == WR_PULSE);

  // Hold request: low only in the DONE cycle, forced low during reset.
  assign stallreq_o = rst & mem_ce_i & (state != DONE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_ce_i) begin
          if (!mem_we_i)       state_nxt = RD;
          else if (|mem_sel_i) state_nxt = WR_SETUP;
          else                 state_nxt = DONE;   // empty write: no SRAM cycle
        end
      end
      RD:       if (wcnt == 4'd0) state_nxt = flush ? IDLE : DONE;
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: if (wcnt == 4'd0) state_nxt = flush ? IDLE : DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Registered SRAM pins, wait counter, read capture and flush tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_ce_n_o <= 1'b1;
      sram_oe_n_o <= 1'b1;
      sram_we_n_o <= 1'b1;
      sram_be_n_o <= 4'hF;
      sram_addr_o <= '0;
      sram_data_o <= '0;
      mem_data_o  <= '0;
      wcnt        <= '0;
      abandon     <= 1'b0;
    end else begin
      if (state_nxt == IDLE)        abandon <= 1'b0;
      else if (busy && !mem_ce_i)   abandon <= 1'b1;

      case (state)
        IDLE: begin
          sram_be_n_o <= 4'hF;
          if (mem_ce_i && !mem_we_i) begin
            sram_addr_o <= mem_addr_i[ADDR_W+1:2];
            sram_ce_n_o <= 1'b0;
            sram_oe_n_o <= 1'b0;
            sram_be_n_o <= 4'h0;
            wcnt        <= RD_LOAD;
          end else if (mem_ce_i && (|mem_sel_i)) begin
            sram_addr_o <= mem_addr_i[ADDR_W+1:2];
            sram_data_o <= mem_data_i;
            sram_ce_n_o <= 1'b0;
            sram_be_n_o <= ~mem_sel_i;
          end
        end
        RD: begin
          if (wcnt == 4'd0) begin
            mem_data_o  <= sram_data_i;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_be_n_o <= 4'hF;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        WR_SETUP: begin
          sram_we_n_o <= 1'b0;
          wcnt        <= WR_LOAD;
        end
        WR_PULSE: begin
          // Address and data stay put for one cycle after we_n rises.
          if (wcnt == 4'd0) begin
            sram_we_n_o <= 1'b1;
            sram_ce_n_o <= 1'b1;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        DONE: begin
          sram_ce_n_o <= 1'b1;
          sram_oe_n_o <= 1'b1;
          sram_we_n_o <= 1'b1;
          sram_be_n_o <= 4'hF;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl with a small async SRAM model.
module tb_data_sram_ctrl;

  localparam int ADDR_W = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_ce_i, mem_we_i;
  logic [3:0]        mem_sel_i;
  logic [31:0]       mem_addr_i, mem_data_i, mem_data_o;
  logic              stallreq_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [31:0]       sram_data_o, sram_data_i;
  logic              sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic [3:0]        sram_be_n_o;

  int checks = 0;
  int errors = 0;

  data_sram_ctrl #(.ADDR_W(ADDR_W), .RD_WAIT(2), .WR_WAIT(2)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .stallreq_o(stallreq_o),
    .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
    .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o),
    .sram_be_n_o(sram_be_n_o)
  );

  always #5 clk = ~clk;

  // SRAM model: async read, byte-lane write while ce_n and we_n are low.
  logic [31:0] mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_a;
  logic [31:0] pre_d;
  assign sram_data_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[11:0]] : 32'h0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (!sram_ce_n_o && !sram_we_n_o)
      for (int i = 0; i < 4; i++)
        if (!sram_be_n_o[i]) mem[sram_addr_o[11:0]][8*i +: 8] <= sram_data_o[8*i +: 8];
  end

  // Per-cycle activity counters.
  logic cnt_clr = 1'b0;
  int oe_cnt, we_cnt, ce_cnt, stall_cnt;
  always @(posedge clk) begin
    if (cnt_clr) begin
      oe_cnt <= 0; we_cnt <= 0; ce_cnt <= 0; stall_cnt <= 0;
    end else begin
      if (!sram_oe_n_o) oe_cnt    <= oe_cnt + 1;
      if (!sram_we_n_o) we_cnt    <= we_cnt + 1;
      if (!sram_ce_n_o) ce_cnt    <= ce_cnt + 1;
      if (stallreq_o)   stall_cnt <= stall_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pre_a = a; pre_d = d; pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  // Wait through the stall until the DONE cycle; returns stall-high cycles.
  task automatic wait_done(input string tag, output int cyc);
    #1;
    cyc = 0;
    while (stallreq_o === 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_timeout"}, {31'b0, stallreq_o}, 32'h0);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int cyc);
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = a;
    wait_done("rd", cyc);
    d = mem_data_o;
    mem_ce_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, output int cyc);
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = s; mem_addr_i = a; mem_data_i = d;
    wait_done("wr", cyc);
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  int          cyc;

  initial begin
    rst = 1'b0;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'h0;
    mem_addr_i = 32'h0; mem_data_i = 32'h0;

    // Reset state; stall is forced low even with ce asserted.
    #12;
    chk("rst_stall", {31'b0, stallreq_o}, 32'h0);
    chk("rst_ce_n",  {31'b0, sram_ce_n_o}, 32'h1);
    chk("rst_oe_n",  {31'b0, sram_oe_n_o}, 32'h1);
    chk("rst_we_n",  {31'b0, sram_we_n_o}, 32'h1);
    chk("rst_be_n",  {28'b0, sram_be_n_o}, 32'hF);
    chk("rst_addr",  {14'b0, sram_addr_o}, 32'h0);
    chk("rst_mdata", mem_data_o, 32'h0);
    mem_ce_i = 1'b0;

    preload(12'h400, 32'hCAFEBABE);
    preload(12'h800, 32'h11223344);
    preload(12'hC00, 32'hA5A50F0F);
    preload(12'hC01, 32'h00000000);
    preload(12'h000, 32'h00000000);
    rst = 1'b1;
    @(posedge clk); #1;
    clr_cnt();

    // 1: read 0x1000, cycle by cycle.
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h1000; mem_sel_i = 4'hF;
    #1 chk("t1_stall_acc", {31'b0, stallreq_o}, 32'h1);
    @(posedge clk); #1;
    chk("t1_ce_n",  {31'b0, sram_ce_n_o}, 32'h0);
    chk("t1_oe_n",  {31'b0, sram_oe_n_o}, 32'h0);
    chk("t1_be_n",  {28'b0, sram_be_n_o}, 32'h0);
    chk("t1_addr",  {14'b0, sram_addr_o}, 32'h400);
    @(posedge clk); @(posedge clk); #1;
    chk("t1_done_stall", {31'b0, stallreq_o}, 32'h0);
    chk("t1_done_oe_n",  {31'b0, sram_oe_n_o}, 32'h1);
    chk("t1_rdata", mem_data_o, 32'hCAFEBABE);
    mem_ce_i = 1'b0;
    @(posedge clk); #1;
    chk("t1_stall_cyc", stall_cnt, 3);
    chk("t1_oe_cyc", oe_cnt, 2);

    // 2: partial write, one lane.
    clr_cnt();
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0010;
    mem_addr_i = 32'h2002; mem_data_i = 32'h55555555;
    @(posedge clk); #1;
    chk("t2_setup_ce_n", {31'b0, sram_ce_n_o}, 32'h0);
    chk("t2_setup_we_n", {31'b0, sram_we_n_o}, 32'h1);
    chk("t2_be_n",  {28'b0, sram_be_n_o}, 32'hD);
    chk("t2_addr",  {14'b0, sram_addr_o}, 32'h800);
    chk("t2_wdata", sram_data_o, 32'h55555555);
    @(posedge clk); #1;
    chk("t2_pulse_we_n", {31'b0, sram_we_n_o}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    chk("t2_done_stall", {31'b0, stallreq_o}, 32'h0);
    chk("t2_done_we_n",  {31'b0, sram_we_n_o}, 32'h1);
    chk("t2_hold_addr",  {14'b0, sram_addr_o}, 32'h800);
    chk("t2_hold_data",  sram_data_o, 32'h55555555);
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    @(posedge clk); #1;
    chk("t2_we_cyc", we_cnt, 2);
    chk("t2_stall_cyc", stall_cnt, 4);
    do_read(32'h2000, rd, cyc);
    chk("t2_readback", rd, 32'h11225544);
    chk("t2_mdata_kept", mem_data_o, 32'h11225544);

    // 3: write with no byte lanes.
    clr_cnt();
    do_write(32'h0000, 4'b0000, 32'hFFFFFFFF, cyc);
    chk("t3_stall_cyc", cyc, 1);
    chk("t3_we_cyc", we_cnt, 0);
    chk("t3_ce_cyc", ce_cnt, 0);
    chk("t3_mdata_kept", mem_data_o, 32'h11225544);

    // 4: read then write back-to-back, one dead IDLE cycle between.
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h3000; mem_sel_i = 4'hF;
    wait_done("t4_rd", cyc);
    chk("t4_rd_cyc", cyc, 3);
    chk("t4_rdata", mem_data_o, 32'hA5A50F0F);
    mem_we_i = 1'b1; mem_addr_i = 32'h3004; mem_sel_i = 4'hF; mem_data_i = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("t4_dead_stall", {31'b0, stallreq_o}, 32'h1);
    chk("t4_dead_ce_n",  {31'b0, sram_ce_n_o}, 32'h1);
    @(posedge clk); #1;
    chk("t4_setup_ce_n", {31'b0, sram_ce_n_o}, 32'h0);
    chk("t4_setup_we_n", {31'b0, sram_we_n_o}, 32'h1);
    chk("t4_setup_addr", {14'b0, sram_addr_o}, 32'hC01);
    wait_done("t4_wr", cyc);
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    @(posedge clk); #1;
    do_read(32'h3004, rd, cyc);
    chk("t4_wr_readback", rd, 32'hDEADBEEF);
    do_read(32'h3000, rd, cyc);
    chk("t4_rd_untouched", rd, 32'hA5A50F0F);

    // 5: flush in the first WR_PULSE cycle.
    clr_cnt();
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'hF;
    mem_addr_i = 32'h4000; mem_data_i = 32'h12345678;
    @(posedge clk); @(posedge clk); #1;
    chk("t5_pulse_we_n", {31'b0, sram_we_n_o}, 32'h0);
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    #1 chk("t5_flush_stall", {31'b0, stallreq_o}, 32'h0);
    @(posedge clk); #1;
    chk("t5_pulse2_we_n", {31'b0, sram_we_n_o}, 32'h0);
    chk("t5_flush_stall2", {31'b0, stallreq_o}, 32'h0);
    @(posedge clk); #1;
    chk("t5_end_we_n", {31'b0, sram_we_n_o}, 32'h1);
    chk("t5_end_ce_n", {31'b0, sram_ce_n_o}, 32'h1);
    chk("t5_we_cyc", we_cnt, 2);
    // Already back in IDLE: the read is accepted now and stalls the full read time.
    do_read(32'h4000, rd, cyc);
    chk("t5_no_done_cyc", cyc, 3);
    chk("t5_readback", rd, 32'h12345678);

    // 6: async reset in the middle of a read.
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h1000; mem_sel_i = 4'hF;
    @(posedge clk); #1;
    chk("t6_rd_oe_n", {31'b0, sram_oe_n_o}, 32'h0);
    #3 rst = 1'b0;
    #1;
    chk("t6_rst_oe_n",  {31'b0, sram_oe_n_o}, 32'h1);
    chk("t6_rst_ce_n",  {31'b0, sram_ce_n_o}, 32'h1);
    chk("t6_rst_be_n",  {28'b0, sram_be_n_o}, 32'hF);
    chk("t6_rst_addr",  {14'b0, sram_addr_o}, 32'h0);
    chk("t6_rst_mdata", mem_data_o, 32'h0);
    chk("t6_rst_stall", {31'b0, stallreq_o}, 32'h0);
    mem_ce_i = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    do_read(32'h1000, rd, cyc);
    chk("t6_after_cyc", cyc, 3);
    chk("t6_after_rdata", rd, 32'hCAFEBABE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
